gray_conv: RTL and testbench

- Registered, parameterised binary/Gray code converter with a valid qualifier.
- Default direction: binary input to reflected-binary Gray output. A mode input selects the inverse (Gray to binary).
- Sits between counters and pointer/clock-domain-crossing logic (e.g. FIFO pointers), so downstream logic sees a clean, glitch-free registered code.

---
 rtl/gray_conv.sv | 85 ++++++++
 tb/tb_gray_conv.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/gray_conv.sv
// gray_conv: registered binary <-> reflected-binary Gray converter.
// mode_i = 0 converts binary to Gray, mode_i = 1 converts Gray to binary.
// The word, its mode and the valid flag are registered together, so the
// outputs come straight from flops with exactly one cycle of latency.
module gray_conv #(
  parameter int wrd_len = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [wrd_len-1:0] bin_i,
  input  logic               mode_i,
  input  logic               valid_i,
  output logic [wrd_len-1:0] gray_o,
  output logic               valid_o,
  output logic               mode_o
);

  // Binary to Gray: each bit is the XOR of itself and its upper neighbour.
  function automatic logic [wrd_len-1:0] bin2gray(input logic [wrd_len-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Gray to binary: MSB-first prefix XOR, bit k = XOR of g[wrd_len-1:k].
  // Folding shifted copies keeps this a single combinational XOR tree.
  function automatic logic [wrd_len-1:0] gray2bin(input logic [wrd_len-1:0] g);
    logic [wrd_len-1:0] b;
    b = g;
    for (int i = 1; i < wrd_len; i++) begin
      b = b ^ (g >> i);
    end
    return b;
  endfunction

  logic [wrd_len-1:0] conv_d;
  logic [wrd_len-1:0] gray_d;
  logic [wrd_len-1:0] gray_q;
  logic               valid_d;
  logic               valid_q;
  logic               mode_d;
  logic               mode_q;

  // Select the conversion direction for the word presented this cycle.
  always_comb begin
    conv_d = bin2gray(bin_i);
    case (mode_i)
      1'b0:    conv_d = bin2gray(bin_i);
      1'b1:    conv_d = gray2bin(bin_i);
      default: conv_d = bin2gray(bin_i);
    endcase
  end

  // Next-state: capture a new word on valid, otherwise hold word and mode.
  always_comb begin
    gray_d  = gray_q;
    mode_d  = mode_q;
    valid_d = 1'b0;
    if (valid_i) begin
      gray_d  = conv_d;
      mode_d  = mode_i;
      valid_d = 1'b1;
    end else begin
      gray_d  = gray_q;
      mode_d  = mode_q;
      valid_d = 1'b0;
    end
  end

  // Output registers; reset clears everything immediately, no clock needed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gray_q  <= {wrd_len{1'b0}};
      valid_q <= 1'b0;
      mode_q  <= 1'b0;
    end else begin
      gray_q  <= gray_d;
      valid_q <= valid_d;
      mode_q  <= mode_d;
    end
  end

  assign gray_o  = gray_q;
  assign valid_o = valid_q;
  assign mode_o  = mode_q;

endmodule

// File: tb/tb_gray_conv.sv
// Self-checking bench for gray_conv: a 5-bit and a 1-bit instance are checked
// every cycle against a behavioural model, plus directed literal checks.
module tb_gray_conv;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [4:0] bin_i = 5'd0;
  logic       mode_i = 1'b0;
  logic       valid_i = 1'b0;
  logic [4:0] gray_o;
  logic       valid_o;
  logic       mode_o;

  logic [0:0] b1_i = 1'b0;
  logic       m1_i = 1'b0;
  logic       v1_i = 1'b0;
  logic [0:0] g1_o;
  logic       v1_o;
  logic       m1_o;

  int checks = 0;
  int errors = 0;

  gray_conv #(.wrd_len(5)) u_dut5 (
    .clk(clk), .rst(rst), .bin_i(bin_i), .mode_i(mode_i), .valid_i(valid_i),
    .gray_o(gray_o), .valid_o(valid_o), .mode_o(mode_o)
  );

  gray_conv #(.wrd_len(1)) u_dut1 (
    .clk(clk), .rst(rst), .bin_i(b1_i), .mode_i(m1_i), .valid_i(v1_i),
    .gray_o(g1_o), .valid_o(v1_o), .mode_o(m1_o)
  );

  always #5 clk = ~clk;

  // Reference: Gray code of b is b ^ (b >> 1) within w bits.
  function automatic int unsigned to_gray(input int unsigned b, input int w);
    int unsigned mask;
    mask = (32'd1 << w) - 32'd1;
    return (b ^ (b >> 1)) & mask;
  endfunction

  // Reference inverse: the unique w-bit value whose Gray code is g.
  function automatic int unsigned from_gray(input int unsigned g, input int w);
    for (int unsigned x = 0; x < (32'd1 << w); x++) begin
      if (to_gray(x, w) == g) return x;
    end
    return 32'hFFFF_FFFF;
  endfunction

  function automatic int unsigned model_conv(input int unsigned v, input logic m, input int w);
    return m ? from_gray(v, w) : to_gray(v, w);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Expected outputs: what the spec says must be visible after each edge.
  logic [4:0] exp_g = 5'd0;
  logic       exp_v = 1'b0;
  logic       exp_m = 1'b0;
  logic [0:0] exp1_g = 1'b0;
  logic       exp1_v = 1'b0;
  logic       exp1_m = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_g <= 5'd0; exp_v <= 1'b0; exp_m <= 1'b0;
      exp1_g <= 1'b0; exp1_v <= 1'b0; exp1_m <= 1'b0;
    end else begin
      exp_v  <= valid_i;
      exp1_v <= v1_i;
      if (valid_i) begin
        exp_g <= 5'(model_conv(32'(bin_i), mode_i, 5));
        exp_m <= mode_i;
      end
      if (v1_i) begin
        exp1_g <= 1'(model_conv(32'(b1_i), m1_i, 1));
        exp1_m <= m1_i;
      end
    end
  end

  // Compare process: outputs are checked mid-cycle, away from the clock edge.
  always @(negedge clk) begin
    chk("cyc_gray5",  32'(gray_o),  32'(exp_g));
    chk("cyc_valid5", 32'(valid_o), 32'(exp_v));
    chk("cyc_mode5",  32'(mode_o),  32'(exp_m));
    chk("cyc_gray1",  32'(g1_o),    32'(exp1_g));
    chk("cyc_valid1", 32'(v1_o),    32'(exp1_v));
    chk("cyc_mode1",  32'(m1_o),    32'(exp1_m));
  end

  // Present one word at the falling edge, then sample just after the rising edge.
  task automatic step(input logic [4:0] b, input logic m, input logic v);
    @(negedge clk);
    bin_i = b; mode_i = m; valid_i = v;
    @(posedge clk);
    #1;
  endtask

  task automatic step1(input logic b, input logic m, input logic v);
    @(negedge clk);
    b1_i = b; m1_i = m; v1_i = v;
    @(posedge clk);
    #1;
  endtask

  logic [4:0] prev_g;

  initial begin
    #1 rst = 1'b1;
    #1;
    chk("rst_gray",  32'(gray_o),  32'd0);
    chk("rst_valid", 32'(valid_o), 32'd0);
    chk("rst_mode",  32'(mode_o),  32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Directed values, mode 0.
    step(5'b01011, 1'b0, 1'b1);
    chk("dir_01011", 32'(gray_o), 32'b01110);
    chk("dir_v1", 32'(valid_o), 32'd1);
    step(5'b10000, 1'b0, 1'b1);
    chk("dir_10000", 32'(gray_o), 32'b11000);
    step(5'b11111, 1'b0, 1'b1);
    chk("dir_11111", 32'(gray_o), 32'b10000);
    step(5'b00000, 1'b0, 1'b1);
    chk("dir_00000", 32'(gray_o), 32'b00000);
    chk("dir_v4", 32'(valid_o), 32'd1);

    // Sweep 0..31 then wrap to 0: one-bit steps throughout.
    for (int i = 0; i <= 32; i++) begin
      step(5'(i % 32), 1'b0, 1'b1);
      chk("sweep_val", 32'(gray_o), (i % 32) ^ ((i % 32) >> 1));
      if (i > 0) chk("sweep_onebit", 32'($countones(prev_g ^ gray_o)), 32'd1);
      prev_g = gray_o;
    end

    // Inverse mode.
    step(5'b10000, 1'b1, 1'b1);
    chk("inv_10000", 32'(gray_o), 32'b11111);
    chk("inv_mode", 32'(mode_o), 32'd1);
    step(5'b01110, 1'b1, 1'b1);
    chk("inv_01110", 32'(gray_o), 32'b01011);
    for (int i = 0; i < 32; i++) begin
      step(5'(i ^ (i >> 1)), 1'b1, 1'b1);
      chk("roundtrip", 32'(gray_o), 32'(i));
    end

    // Valid gaps with alternating mode: 1,0,0,1.
    step(5'b00110, 1'b0, 1'b1);
    chk("gap_w0", 32'(gray_o), 32'b00101);
    chk("gap_v0", 32'(valid_o), 32'd1);
    step(5'b11111, 1'b1, 1'b0);
    chk("gap_hold1", 32'(gray_o), 32'b00101);
    chk("gap_v1", 32'(valid_o), 32'd0);
    chk("gap_m1", 32'(mode_o), 32'd0);
    step(5'b11111, 1'b0, 1'b0);
    chk("gap_hold2", 32'(gray_o), 32'b00101);
    chk("gap_v2", 32'(valid_o), 32'd0);
    step(5'b00110, 1'b1, 1'b1);
    chk("gap_w3", 32'(gray_o), 32'b00100);
    chk("gap_v3", 32'(valid_o), 32'd1);
    chk("gap_m3", 32'(mode_o), 32'd1);

    // Width corner, wrd_len = 1.
    step1(1'b0, 1'b0, 1'b1); chk("w1_b0_m0", 32'(g1_o), 32'd0);
    step1(1'b1, 1'b0, 1'b1); chk("w1_b1_m0", 32'(g1_o), 32'd1);
    step1(1'b0, 1'b1, 1'b1); chk("w1_b0_m1", 32'(g1_o), 32'd0);
    step1(1'b1, 1'b1, 1'b1); chk("w1_b1_m1", 32'(g1_o), 32'd1);
    chk("w1_mode", 32'(m1_o), 32'd1);

    // Mid-cycle reset with a word pending.
    step(5'b11111, 1'b1, 1'b1);
    chk("pre_rst_gray", 32'(gray_o), 32'b10101);
    @(negedge clk);
    bin_i = 5'b01011; mode_i = 1'b1; valid_i = 1'b1;
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_gray",  32'(gray_o),  32'd0);
    chk("mid_rst_valid", 32'(valid_o), 32'd0);
    chk("mid_rst_mode",  32'(mode_o),  32'd0);
    @(negedge clk);
    rst = 1'b0; valid_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(5'b01011, 1'b1, 1'b0);
      chk("post_rst_gray",  32'(gray_o),  32'd0);
      chk("post_rst_valid", 32'(valid_o), 32'd0);
    end

    // Randomised traffic on both instances, with occasional resets.
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      bin_i   = 5'($urandom_range(0, 31));
      mode_i  = 1'($urandom_range(0, 1));
      valid_i = ($urandom_range(0, 3) != 0);
      b1_i    = 1'($urandom_range(0, 1));
      m1_i    = 1'($urandom_range(0, 1));
      v1_i    = 1'($urandom_range(0, 1));
      rst     = ($urandom_range(0, 49) == 0);
    end
    @(negedge clk);
    rst = 1'b0; valid_i = 1'b0; v1_i = 1'b0;
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
